// File: rtl/hpu_task_ctrl.sv
// hpu_task_ctrl: per-HPU task endpoint.
// It accepts one handler task from the cluster scheduler and holds it for the
// core. It tracks execution until the core reports done, then returns a
// completion descriptor to the scheduler.
// Optional build macro: HPU_TASK_CTRL_WATCHDOG_EN adds a Running-state watchdog.

package hpu_task_ctrl_pkg;

    typedef struct packed {
        logic [9:0]  msgid;
        logic [31:0] handler_fun;
        logic [31:0] handler_mem_addr;
        logic [31:0] pkt_addr;
        logic [15:0] pkt_size;
        logic        trigger_feedback;
    } handler_task_t;

    typedef struct packed {
        handler_task_t handler_task;
        logic [31:0]   pkt_ptr;
    } hpu_handler_task_t;

    typedef struct packed {
        logic [9:0]  msgid;
        logic        trigger_feedback;
        logic [31:0] pkt_addr;
        logic [15:0] pkt_size;
        logic [7:0]  status;
    } feedback_descr_t;

    typedef struct packed {
        feedback_descr_t feedback_descr;
        logic [31:0]     pkt_ptr;
    } task_feedback_descr_t;

endpackage

module hpu_task_ctrl
    import hpu_task_ctrl_pkg::*;
#(
    parameter int HPU_ID         = 0,
    parameter int STAT_CNT_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      task_valid_i,
    output logic                      task_ready_o,
    input  hpu_handler_task_t         task_i,
    output logic                      core_task_valid_o,
    output hpu_handler_task_t         core_task_o,
    input  logic                      core_pick_i,
    input  logic                      core_done_i,
    output logic                      feedback_valid_o,
    input  logic                      feedback_ready_i,
    output task_feedback_descr_t      feedback_o,
    output logic                      active_o,
    output logic [STAT_CNT_WIDTH-1:0] completed_cnt_o,
    output logic [STAT_CNT_WIDTH-1:0] last_runtime_o,
    output logic                      timeout_o
);

    localparam logic [STAT_CNT_WIDTH-1:0] CNT_ONE = {{(STAT_CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOADED   = 2'd1,
        ST_RUNNING  = 2'd2,
        ST_FEEDBACK = 2'd3
    } state_e;

    state_e                     r_state;
    hpu_handler_task_t          r_task;
    task_feedback_descr_t       r_feedback;
    logic                       r_core_task_valid;
    logic                       r_feedback_valid;
    logic                       r_active;
    logic                       r_timeout;
    logic [STAT_CNT_WIDTH-1:0]  r_completed_cnt;
    logic [STAT_CNT_WIDTH-1:0]  r_runtime;
    logic [STAT_CNT_WIDTH-1:0]  r_last_runtime;

    logic [STAT_CNT_WIDTH-1:0]  w_runtime_inc;
    logic [STAT_CNT_WIDTH-1:0]  w_completed_inc;
    logic                       w_timeout;
    logic                       w_end_run;
    task_feedback_descr_t       w_feedback;
    // HPU_ID is a tag for the stats consumer only; it shapes no logic here.
    logic [31:0]                w_unused_params;

    assign w_unused_params = 32'(HPU_ID) ^ 32'(TIMEOUT_CYCLES);

    // Both statistics counters stick at all-ones instead of wrapping.
    assign w_runtime_inc   = (&r_runtime)       ? r_runtime       : r_runtime + CNT_ONE;
    assign w_completed_inc = (&r_completed_cnt) ? r_completed_cnt : r_completed_cnt + CNT_ONE;

`ifdef HPU_TASK_CTRL_WATCHDOG_EN
    localparam logic [STAT_CNT_WIDTH-1:0] TIMEOUT_LIM = STAT_CNT_WIDTH'(TIMEOUT_CYCLES);
    // A real done that lands on the limit cycle wins; no timeout is flagged.
    assign w_timeout = (r_state == ST_RUNNING) && !core_done_i && (w_runtime_inc == TIMEOUT_LIM);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_end_run = (r_state == ST_RUNNING) && (core_done_i || w_timeout);

    // Build the completion descriptor from the latched task; unmatched fields stay 0.
    always_comb begin
        w_feedback                                 = '0;
        w_feedback.feedback_descr.msgid            = r_task.handler_task.msgid;
        w_feedback.feedback_descr.trigger_feedback = r_task.handler_task.trigger_feedback;
        w_feedback.feedback_descr.pkt_addr         = r_task.handler_task.pkt_addr;
        w_feedback.feedback_descr.pkt_size         = r_task.handler_task.pkt_size;
        w_feedback.pkt_ptr                         = r_task.pkt_ptr;
    end

    // Task lifecycle FSM with registered outputs and statistics.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state           <= ST_IDLE;
            r_task            <= '0;
            r_feedback        <= '0;
            r_core_task_valid <= 1'b0;
            r_feedback_valid  <= 1'b0;
            r_active          <= 1'b0;
            r_timeout         <= 1'b0;
            r_completed_cnt   <= '0;
            r_runtime         <= '0;
            r_last_runtime    <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (task_valid_i) begin
                        r_task            <= task_i;
                        r_core_task_valid <= 1'b1;
                        r_active          <= 1'b1;
                        r_state           <= ST_LOADED;
                    end
                end
                ST_LOADED: begin
                    // A done arriving together with the pick is deliberately dropped.
                    if (core_pick_i) begin
                        r_core_task_valid <= 1'b0;
                        r_runtime         <= '0;
                        r_state           <= ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    r_runtime <= w_runtime_inc;
                    if (w_end_run) begin
                        r_last_runtime   <= w_runtime_inc;
                        r_feedback       <= w_feedback;
                        r_feedback_valid <= 1'b1;
                        r_timeout        <= w_timeout;
                        r_state          <= ST_FEEDBACK;
                    end
                end
                ST_FEEDBACK: begin
                    // Feedback is held until the scheduler takes it.
                    if (feedback_ready_i) begin
                        r_feedback_valid <= 1'b0;
                        r_active         <= 1'b0;
                        r_completed_cnt  <= w_completed_inc;
                        r_state          <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign task_ready_o      = (r_state == ST_IDLE);
    assign core_task_valid_o = r_core_task_valid;
    assign core_task_o       = r_task;
    assign feedback_valid_o  = r_feedback_valid;
    assign feedback_o        = r_feedback;
    assign active_o          = r_active;
    assign completed_cnt_o   = r_completed_cnt;
    assign last_runtime_o    = r_last_runtime;
    assign timeout_o         = r_timeout;

endmodule

// File: tb/tb_hpu_task_ctrl.sv
// Self-checking bench for hpu_task_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_hpu_task_ctrl;
    import hpu_task_ctrl_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  task_valid_i = 1'b0;
    logic                  task_ready_o;
    hpu_handler_task_t     task_i = '0;
    logic                  core_task_valid_o;
    hpu_handler_task_t     core_task_o;
    logic                  core_pick_i = 1'b0;
    logic                  core_done_i = 1'b0;
    logic                  feedback_valid_o;
    logic                  feedback_ready_i = 1'b0;
    task_feedback_descr_t  feedback_o;
    logic                  active_o;
    logic [31:0]           completed_cnt_o;
    logic [31:0]           last_runtime_o;
    logic                  timeout_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_completed = 0;

    hpu_task_ctrl #(
        .HPU_ID(2),
        .STAT_CNT_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .task_valid_i(task_valid_i),
        .task_ready_o(task_ready_o),
        .task_i(task_i),
        .core_task_valid_o(core_task_valid_o),
        .core_task_o(core_task_o),
        .core_pick_i(core_pick_i),
        .core_done_i(core_done_i),
        .feedback_valid_o(feedback_valid_o),
        .feedback_ready_i(feedback_ready_i),
        .feedback_o(feedback_o),
        .active_o(active_o),
        .completed_cnt_o(completed_cnt_o),
        .last_runtime_o(last_runtime_o),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    function automatic hpu_handler_task_t rand_task();
        hpu_handler_task_t t;
        t.handler_task.msgid            = 10'($urandom);
        t.handler_task.handler_fun      = $urandom;
        t.handler_task.handler_mem_addr = $urandom;
        t.handler_task.pkt_addr         = $urandom;
        t.handler_task.pkt_size         = 16'($urandom);
        t.handler_task.trigger_feedback = 1'($urandom);
        t.pkt_ptr                       = $urandom;
        return t;
    endfunction

    // Expected completion descriptor: same-named fields copied, the rest zero.
    function automatic task_feedback_descr_t fb_model(hpu_handler_task_t t);
        task_feedback_descr_t f;
        f.feedback_descr.msgid            = t.handler_task.msgid;
        f.feedback_descr.trigger_feedback = t.handler_task.trigger_feedback;
        f.feedback_descr.pkt_addr         = t.handler_task.pkt_addr;
        f.feedback_descr.pkt_size         = t.handler_task.pkt_size;
        f.feedback_descr.status           = 8'h00;
        f.pkt_ptr                         = t.pkt_ptr;
        return f;
    endfunction

    task automatic test_reset();
        checks++; if (task_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", task_ready_o); end
        checks++; if (active_o !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", active_o); end
        checks++; if (feedback_valid_o !== 1'b0) begin errors++; $display("FAIL reset_fb_valid got=%b exp=0", feedback_valid_o); end
        checks++; if (completed_cnt_o !== 32'd0) begin errors++; $display("FAIL reset_completed got=%0d exp=0", completed_cnt_o); end
        checks++; if (core_task_valid_o !== 1'b0) begin errors++; $display("FAIL reset_core_valid got=%b exp=0", core_task_valid_o); end
        checks++; if (core_task_o !== '0 || feedback_o !== '0) begin errors++; $display("FAIL reset_regs task=%h fb=%h exp=0", core_task_o, feedback_o); end
        checks++; if (last_runtime_o !== 32'd0 || timeout_o !== 1'b0) begin errors++; $display("FAIL reset_stats rt=%0d to=%b exp=0", last_runtime_o, timeout_o); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        hpu_handler_task_t t;
        int t_pick, t_done;
        t = rand_task();
        t.handler_task.msgid = 10'd3;
        t.handler_task.pkt_size = 16'd128;
        t.pkt_ptr = 32'h001C_0400;
        task_i = t; task_valid_i = 1'b1;
        step();
        task_valid_i = 1'b0; task_i = '0;
        checks++; if (core_task_valid_o !== 1'b1 || task_ready_o !== 1'b0 || active_o !== 1'b1) begin errors++; $display("FAIL single_loaded cv=%b rdy=%b act=%b exp=1,0,1", core_task_valid_o, task_ready_o, active_o); end
        checks++; if (core_task_o !== t) begin errors++; $display("FAIL single_task got=%h exp=%h", core_task_o, t); end
        step();
        core_pick_i = 1'b1; step(); t_pick = cyc; core_pick_i = 1'b0;
        checks++; if (core_task_valid_o !== 1'b0) begin errors++; $display("FAIL single_cv_running got=%b exp=0", core_task_valid_o); end
        repeat (9) step();
        checks++; if (feedback_valid_o !== 1'b0) begin errors++; $display("FAIL single_fb_early got=%b exp=0", feedback_valid_o); end
        core_done_i = 1'b1; step(); t_done = cyc; core_done_i = 1'b0;
        checks++; if (feedback_valid_o !== 1'b1 || core_task_valid_o !== 1'b0) begin errors++; $display("FAIL single_fb_valid fv=%b cv=%b exp=1,0", feedback_valid_o, core_task_valid_o); end
        checks++; if (feedback_o !== fb_model(t)) begin errors++; $display("FAIL single_fb got=%h exp=%h", feedback_o, fb_model(t)); end
        checks++; if (last_runtime_o !== 32'(t_done - t_pick) || t_done - t_pick != 10) begin errors++; $display("FAIL single_runtime got=%0d exp=10", last_runtime_o); end
        feedback_ready_i = 1'b1; step(); feedback_ready_i = 1'b0; exp_completed++;
        checks++; if (completed_cnt_o !== 32'(exp_completed) || task_ready_o !== 1'b1 || active_o !== 1'b0) begin errors++; $display("FAIL single_done cnt=%0d rdy=%b act=%b exp=%0d,1,0", completed_cnt_o, task_ready_o, active_o, exp_completed); end
        $display("test_single msgid=3 runtime=%0d completed=%0d", last_runtime_o, completed_cnt_o);
    endtask

    task automatic test_back_to_back();
        hpu_handler_task_t t, t2;
        t = rand_task(); t2 = rand_task();
        task_i = t; task_valid_i = 1'b1; step();
        task_i = t2; // offered during the whole busy period; must not be taken
        core_pick_i = 1'b1; step(); core_pick_i = 1'b0;
        step();
        core_done_i = 1'b1; step(); core_done_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            checks++; if (feedback_valid_o !== 1'b1 || feedback_o !== fb_model(t) || task_ready_o !== 1'b0) begin errors++; $display("FAIL bp_hold k=%0d fv=%b rdy=%b fb=%h exp=1,0,%h", k, feedback_valid_o, task_ready_o, feedback_o, fb_model(t)); end
            checks++; if (core_task_o !== t) begin errors++; $display("FAIL bp_task k=%0d got=%h exp=%h", k, core_task_o, t); end
            step();
        end
        feedback_ready_i = 1'b1; step(); feedback_ready_i = 1'b0; exp_completed++;
        checks++; if (task_ready_o !== 1'b1 || completed_cnt_o !== 32'(exp_completed)) begin errors++; $display("FAIL bp_idle rdy=%b cnt=%0d exp=1,%0d", task_ready_o, completed_cnt_o, exp_completed); end
        step(); task_valid_i = 1'b0;
        checks++; if (core_task_o !== t2 || core_task_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_accept task=%h cv=%b exp=%h,1", core_task_o, core_task_valid_o, t2); end
        core_pick_i = 1'b1; step(); core_pick_i = 1'b0;
        core_done_i = 1'b1; step(); core_done_i = 1'b0;
        checks++; if (feedback_o !== fb_model(t2) || last_runtime_o !== 32'd1) begin errors++; $display("FAIL b2b_fb fb=%h rt=%0d exp=%h,1", feedback_o, last_runtime_o, fb_model(t2)); end
        feedback_ready_i = 1'b1; step(); feedback_ready_i = 1'b0; exp_completed++;
        $display("test_back_to_back completed=%0d", completed_cnt_o);
    endtask

    task automatic test_pick_done_same();
        hpu_handler_task_t t;
        int t_pick, t_done;
        t = rand_task();
        task_i = t; task_valid_i = 1'b1; step(); task_valid_i = 1'b0;
        core_pick_i = 1'b1; core_done_i = 1'b1; step(); t_pick = cyc;
        core_pick_i = 1'b0; core_done_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (feedback_valid_o !== 1'b0 || active_o !== 1'b1 || core_task_valid_o !== 1'b0) begin errors++; $display("FAIL same_running k=%0d fv=%b act=%b cv=%b exp=0,1,0", k, feedback_valid_o, active_o, core_task_valid_o); end
            step();
        end
        core_done_i = 1'b1; step(); t_done = cyc; core_done_i = 1'b0;
        checks++; if (feedback_valid_o !== 1'b1 || last_runtime_o !== 32'(t_done - t_pick)) begin errors++; $display("FAIL same_done fv=%b rt=%0d exp=1,%0d", feedback_valid_o, last_runtime_o, t_done - t_pick); end
        feedback_ready_i = 1'b1; step(); feedback_ready_i = 1'b0; exp_completed++;
        $display("test_pick_done_same runtime=%0d", last_runtime_o);
    endtask

    task automatic test_stray();
        hpu_handler_task_t t;
        logic [31:0] rt_before;
        int t_pick, t_done;
        rt_before = last_runtime_o;
        core_done_i = 1'b1; step(); core_done_i = 1'b0;
        core_pick_i = 1'b1; step(); core_pick_i = 1'b0;
        checks++; if (task_ready_o !== 1'b1 || active_o !== 1'b0 || completed_cnt_o !== 32'(exp_completed) || last_runtime_o !== rt_before) begin errors++; $display("FAIL stray_idle rdy=%b act=%b cnt=%0d rt=%0d exp=1,0,%0d,%0d", task_ready_o, active_o, completed_cnt_o, last_runtime_o, exp_completed, rt_before); end
        t = rand_task();
        task_i = t; task_valid_i = 1'b1; step(); task_valid_i = 1'b0;
        core_pick_i = 1'b1; step(); t_pick = cyc; core_pick_i = 1'b0;
        step(); step();
        core_pick_i = 1'b1; step(); core_pick_i = 1'b0;   // stray pick while running
        step();
        core_done_i = 1'b1; step(); t_done = cyc; core_done_i = 1'b0;
        checks++; if (last_runtime_o !== 32'(t_done - t_pick)) begin errors++; $display("FAIL stray_run_pick rt=%0d exp=%0d", last_runtime_o, t_done - t_pick); end
        core_done_i = 1'b1; step(); core_done_i = 1'b0;   // stray done in feedback
        checks++; if (feedback_valid_o !== 1'b1 || feedback_o !== fb_model(t) || last_runtime_o !== 32'(t_done - t_pick)) begin errors++; $display("FAIL stray_fb_done fv=%b rt=%0d exp=1,%0d", feedback_valid_o, last_runtime_o, t_done - t_pick); end
        feedback_ready_i = 1'b1; step(); feedback_ready_i = 1'b0; exp_completed++;
        checks++; if (completed_cnt_o !== 32'(exp_completed)) begin errors++; $display("FAIL stray_cnt got=%0d exp=%0d", completed_cnt_o, exp_completed); end
        $display("test_stray runtime=%0d completed=%0d", last_runtime_o, completed_cnt_o);
    endtask

    task automatic test_watchdog();
        hpu_handler_task_t t;
        int pulses = 0;
        int first = -1;
        t = rand_task();
        task_i = t; task_valid_i = 1'b1; step(); task_valid_i = 1'b0;
        core_pick_i = 1'b1; step(); core_pick_i = 1'b0;
`ifdef HPU_TASK_CTRL_WATCHDOG_EN
        for (int k = 1; k <= 40; k++) begin
            step();
            if (timeout_o === 1'b1) begin pulses++; if (first < 0) first = k; end
        end
        checks++; if (pulses != 1 || first != 16) begin errors++; $display("FAIL wd_pulse count=%0d at=%0d exp=1 at 16", pulses, first); end
        checks++; if (feedback_valid_o !== 1'b1 || feedback_o !== fb_model(t) || last_runtime_o !== 32'd16) begin errors++; $display("FAIL wd_fb fv=%b rt=%0d exp=1,16", feedback_valid_o, last_runtime_o); end
`else
        for (int k = 1; k <= 100; k++) begin
            step();
            if (timeout_o !== 1'b0 || feedback_valid_o !== 1'b0 || active_o !== 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL wd_persist bad_cycles=%0d exp=0", pulses); end
        core_done_i = 1'b1; step(); core_done_i = 1'b0;
        checks++; if (feedback_valid_o !== 1'b1 || last_runtime_o !== 32'd101) begin errors++; $display("FAIL wd_late_done fv=%b rt=%0d exp=1,101", feedback_valid_o, last_runtime_o); end
`endif
        feedback_ready_i = 1'b1; step(); feedback_ready_i = 1'b0; exp_completed++;
        $display("test_watchdog pulses=%0d runtime=%0d", pulses, last_runtime_o);
    endtask

    task automatic test_reset_mid();
        hpu_handler_task_t t;
        int bad = 0;
        t = rand_task();
        task_i = t; task_valid_i = 1'b1; step(); task_valid_i = 1'b0;
        core_pick_i = 1'b1; step(); core_pick_i = 1'b0;
        step();
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (task_ready_o !== 1'b1 || active_o !== 1'b0 || completed_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_async rdy=%b act=%b cnt=%0d exp=1,0,0", task_ready_o, active_o, completed_cnt_o); end
        step(); rst_ni = 1'b1; exp_completed = 0;
        core_done_i = 1'b1; step(); core_done_i = 1'b0;
        for (int k = 0; k < 5; k++) begin step(); if (feedback_valid_o !== 1'b0 || active_o !== 1'b0) bad++; end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_drop bad_cycles=%0d exp=0", bad); end
        $display("test_reset_mid dropped task ok_cycles=%0d", 5 - bad);
    endtask

    task automatic test_random();
        hpu_handler_task_t t;
        int gap, pd, rl, bp, t_pick, t_done;
        for (int n = 0; n < 30; n++) begin
            t = rand_task();
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                core_done_i = 1'($urandom); core_pick_i = 1'($urandom); step();
            end
            core_done_i = 1'b0; core_pick_i = 1'b0;
            checks++; if (task_ready_o !== 1'b1 || completed_cnt_o !== 32'(exp_completed)) begin errors++; $display("FAIL rnd_idle n=%0d rdy=%b cnt=%0d exp=1,%0d", n, task_ready_o, completed_cnt_o, exp_completed); end
            task_i = t; task_valid_i = 1'b1; step(); task_valid_i = 1'b0; task_i = rand_task();
            checks++; if (core_task_o !== t || core_task_valid_o !== 1'b1) begin errors++; $display("FAIL rnd_accept n=%0d task=%h cv=%b exp=%h,1", n, core_task_o, core_task_valid_o, t); end
            pd = $urandom_range(0, 4);
            repeat (pd) step();
            core_pick_i = 1'b1; core_done_i = 1'($urandom); step(); t_pick = cyc;
            core_pick_i = 1'b0; core_done_i = 1'b0;
            rl = $urandom_range(1, 12);
            for (int k = 1; k < rl; k++) begin
                core_pick_i = 1'($urandom); step();
                checks++; if (feedback_valid_o !== 1'b0) begin errors++; $display("FAIL rnd_run n=%0d fv=%b exp=0", n, feedback_valid_o); end
            end
            core_pick_i = 1'b0; core_done_i = 1'b1; step(); t_done = cyc; core_done_i = 1'b0;
            checks++; if (feedback_valid_o !== 1'b1 || feedback_o !== fb_model(t) || last_runtime_o !== 32'(t_done - t_pick)) begin errors++; $display("FAIL rnd_fb n=%0d fv=%b fb=%h rt=%0d exp=1,%h,%0d", n, feedback_valid_o, feedback_o, last_runtime_o, fb_model(t), t_done - t_pick); end
            bp = $urandom_range(0, 5);
            for (int k = 0; k < bp; k++) begin
                core_done_i = 1'($urandom); step();
                checks++; if (feedback_valid_o !== 1'b1 || feedback_o !== fb_model(t)) begin errors++; $display("FAIL rnd_bp n=%0d fv=%b exp=1", n, feedback_valid_o); end
            end
            core_done_i = 1'b0;
            feedback_ready_i = 1'b1; step(); feedback_ready_i = 1'b0; exp_completed++;
            checks++; if (completed_cnt_o !== 32'(exp_completed) || task_ready_o !== 1'b1) begin errors++; $display("FAIL rnd_hs n=%0d cnt=%0d rdy=%b exp=%0d,1", n, completed_cnt_o, task_ready_o, exp_completed); end
            $display("txn %0d msgid=%0d runtime=%0d backpressure=%0d completed=%0d", n, t.handler_task.msgid, t_done - t_pick, bp, completed_cnt_o);
        end
    endtask

    initial begin
        repeat (3) step();
        rst_ni = 1'b1;
        step();
        test_reset();
        test_single();
        test_back_to_back();
        test_pick_done_same();
        test_stray();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hpu_task_ctrl.md
Name: hpu_task_ctrl

Overview:
- Per-HPU task endpoint. It is the receiving end of the cluster scheduler's hpu_task valid/ready interface and the sending end of the per-HPU feedback interface.
- It latches one handler task and presents it to the core. It tracks execution until the core signals done, then returns a task_feedback_descr_t to the cluster scheduler.
- One instance per core, NUM_CORES per cluster. It also drives the HPU activity signal and per-core statistics.

Parameters:
- HPU_ID, 0, core index within the cluster; reported in stats only.
- STAT_CNT_WIDTH, 32, width of the completed-task counter and the runtime counter.
- TIMEOUT_CYCLES, 4096, watchdog limit in Running cycles; used only when the optional feature is compiled in.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- task_valid_i  in  1  task offered by the cluster scheduler.
- task_ready_o  out  1  endpoint can accept a task.
- task_i  in  $bits(hpu_handler_task_t)  task descriptor (handler_task + pkt_ptr).
- core_task_valid_o  out  1  a latched task is waiting for the core to pick it up.
- core_task_o  out  $bits(hpu_handler_task_t)  latched task; stable from accept until feedback handshake.
- core_pick_i  in  1  single-cycle pulse: core has started the handler.
- core_done_i  in  1  single-cycle pulse: handler finished.
- feedback_valid_o  out  1  completion feedback pending.
- feedback_ready_i  in  1  cluster arbiter accepts feedback.
- feedback_o  out  $bits(task_feedback_descr_t)  completion descriptor.
- active_o  out  1  endpoint is busy (state != Idle).
- completed_cnt_o  out  STAT_CNT_WIDTH  completed-task counter; saturating.
- last_runtime_o  out  STAT_CNT_WIDTH  Running-cycle count of the last completed task.
- timeout_o  out  1  watchdog pulse; constant 0 without the feature.

Behaviour:
- FSM states and transitions:
  - Idle -> Loaded on task_valid_i && task_ready_o.
  - Loaded -> Running on core_pick_i.
  - Running -> Feedback on core_done_i.
  - Feedback -> Idle on feedback_valid_o && feedback_ready_i.
- Reset values: state=Idle, task register=0, all outputs 0 except task_ready_o=1, counters 0.
- task_ready_o = (state==Idle). It is purely combinational from state and has no dependency on task_valid_i.
- Task is latched on the accept edge. core_task_valid_o=1 from the next cycle while in Loaded; 0 in every other state. core_task_o holds the register in all states.
- Simultaneous events:
  - core_pick_i and core_done_i in the same Loaded cycle: only the pick is taken (-> Running). The done is ignored.
  - core_done_i in Idle, Loaded or Feedback is ignored.
  - core_pick_i outside Loaded is ignored.
- Runtime counter:
  - Cleared on the pick cycle.
  - Increments every Running cycle, including the done cycle; saturates at all-ones.
  - Copied to last_runtime_o on the done cycle. Example: pick at cycle t, done at t+5 -> last_runtime_o=5.
- feedback_o is registered when entering Feedback:
  - feedback_descr.msgid, .pkt_addr and .pkt_size are copied from task.handler_task; other fields of feedback_descr are copied from same-named handler_task fields where they exist, else 0.
  - pkt_ptr is copied from task.pkt_ptr.
  - The cluster scheduler uses pkt_ptr and pkt_size to free the L1 packet buffer, so both must be exact.
- feedback_valid_o:
  - Rises the cycle after the done pulse.
  - Stays high and feedback_o stays stable until feedback_ready_i; it never drops without a handshake (AXI-style).
- Feedback handshake cycle: completed_cnt_o increments (saturating); next cycle state=Idle, task_ready_o=1. Minimum turnaround is accept -> pick -> done -> feedback -> Idle, with a new accept possible 1 cycle after the feedback handshake.
- Reset mid-operation: the state returns to Idle asynchronously. The in-flight task is dropped and no feedback is emitted.
- active_o is registered-state derived: 1 in Loaded, Running and Feedback.

Optional Feature:
- Macro: HPU_TASK_CTRL_WATCHDOG_EN.
- With the macro: if Running lasts TIMEOUT_CYCLES cycles without core_done_i, the block forces Running -> Feedback exactly as if done had arrived. timeout_o pulses for 1 cycle on the forced cycle. last_runtime_o = TIMEOUT_CYCLES.
  - If done arrives in the same cycle as the timeout, it is treated as a normal done with no timeout pulse.
- Without the macro: no watchdog logic; timeout_o is tied to 0. Running persists indefinitely.

Test Plan:
- Reset then idle: expect task_ready_o=1, active_o=0, feedback_valid_o=0, completed_cnt_o=0.
- Single task (msgid=3, pkt_size=128, pkt_ptr=0x1C0400), pick 2 cycles after accept, done 10 cycles after pick:
  - core_task_valid_o high only in Loaded.
  - feedback_o carries msgid=3, pkt_size=128, pkt_ptr=0x1C0400.
  - last_runtime_o=10, completed_cnt_o=1.
- Feedback backpressure, feedback_ready_i low for 7 cycles: feedback_valid_o stays 1 with feedback_o stable; task_ready_o=0 throughout; Idle 1 cycle after the handshake.
- Same-cycle pick+done in Loaded: state=Running; feedback_valid_o stays 0 until a later done pulse.
- Stray pulses (done in Idle, pick in Running): no state change and no counter change.
- Watchdog build, TIMEOUT_CYCLES=16, no done: timeout_o pulses once 16 cycles after pick; feedback is emitted; last_runtime_o=16. Non-watchdog build: Running persists for 100 cycles.
